// File: rtl/alu_issue_queue_if.sv
// Command and response ports of alu_issue_queue, grouped so producer and consumer
// sides can be bound as a pair.
interface alu_issue_queue_if;
    // Valid/ready: a beat transfers on a rising edge where valid && ready are both high.
    // The source holds valid and payload stable until that edge.
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;
    logic [2:0] cmd_opcode;
    logic       cmd_use_acc;

    logic       rsp_valid;
    logic       rsp_ready;
    logic [3:0] rsp_result;
    logic [2:0] rsp_opcode;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_use_acc, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_opcode
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_opcode, cmd_use_acc, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_opcode
    );
endinterface

// File: rtl/alu_issue_queue.sv
// Command FIFO -> registered issue stage -> registered response for a combinational ALU.
// Define ALU_ISSUE_ACC_EN to let commands take the previous result as operand A.
module alu_issue_queue #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    alu_issue_queue_if.slave           bus,
    output logic [3:0]                 alu_a,
    output logic [3:0]                 alu_b,
    output logic [2:0]                 alu_opcode,
    input  logic [3:0]                 alu_result,
    output logic [$clog2(DEPTH):0]     fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0]   wr_ptr, rd_ptr;
    logic [3:0]    mem_a  [DEPTH];
    logic [3:0]    mem_b  [DEPTH];
    logic [2:0]    mem_op [DEPTH];
    logic          iss_vld;
    logic          rsp_valid;
    logic [3:0]    rsp_result;
    logic [2:0]    rsp_opcode;
    logic [3:0]    head_a;
    logic          full, empty, push, pop, rsp_free, iss_adv;
    logic [AW-1:0] wr_idx, rd_idx;

    assign wr_idx   = wr_ptr[AW-1:0];
    assign rd_idx   = rd_ptr[AW-1:0];
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty    = (wr_ptr == rd_ptr);
    assign push     = bus.cmd_valid && !full;
    assign rsp_free = !rsp_valid || bus.rsp_ready;
    assign iss_adv  = iss_vld && rsp_free;
    assign pop      = !empty && (!iss_vld || iss_adv);

    assign fifo_count     = wr_ptr - rd_ptr;
    assign bus.cmd_ready  = !full;
    assign bus.rsp_valid  = rsp_valid;
    assign bus.rsp_result = rsp_result;
    assign bus.rsp_opcode = rsp_opcode;

`ifdef ALU_ISSUE_ACC_EN
    logic       mem_acc [DEPTH];
    logic [3:0] acc;

    // The result being captured this edge is forwarded so dependent commands need no bubble.
    always_comb begin
        head_a = mem_a[rd_idx];
        if (mem_acc[rd_idx]) head_a = iss_adv ? alu_result : acc;
    end

    always_ff @(posedge clk) begin
        if (push) mem_acc[wr_idx] <= bus.cmd_use_acc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       acc <= '0;
        else if (clr)     acc <= '0;
        else if (iss_adv) acc <= alu_result;
    end
`else
    logic unused_use_acc;
    assign unused_use_acc = bus.cmd_use_acc;

    always_comb head_a = mem_a[rd_idx];
`endif

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_idx]  <= bus.cmd_a;
            mem_b[wr_idx]  <= bus.cmd_b;
            mem_op[wr_idx] <= bus.cmd_opcode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            iss_vld    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_opcode <= '0;
        end else if (clr) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            iss_vld    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_opcode <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;

            if (pop) begin
                iss_vld    <= 1'b1;
                alu_a      <= head_a;
                alu_b      <= mem_b[rd_idx];
                alu_opcode <= mem_op[rd_idx];
            end else if (iss_adv) begin
                iss_vld    <= 1'b0;
            end

            // Capture uses the opcode still on the issue register, paired with its result.
            if (iss_adv) begin
                rsp_valid  <= 1'b1;
                rsp_result <= alu_result;
                rsp_opcode <= alu_opcode;
            end else if (bus.rsp_ready) begin
                rsp_valid  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue with a behavioural simple_alu on the ALU port.
// The accumulator sequence runs only when ALU_ISSUE_ACC_EN is defined.
module tb_alu_issue_queue;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [3:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_opcode;
    logic [2:0] fifo_count;

    int errors = 0;
    int checks = 0;
    logic [3:0] exp_q[$];

    alu_issue_queue_if bus();

    alu_issue_queue #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .bus        (bus),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always_comb begin
        case (alu_opcode)
            3'b000:  alu_result = alu_a + alu_b;
            3'b001:  alu_result = alu_a - alu_b;
            3'b010:  alu_result = alu_a & alu_b;
            3'b011:  alu_result = alu_a | alu_b;
            3'b100:  alu_result = ~alu_a;
            default: alu_result = 4'h0;
        endcase
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b,
                         input logic [2:0] op, input logic ua);
        bus.cmd_valid   = v;
        bus.cmd_a       = a;
        bus.cmd_b       = b;
        bus.cmd_opcode  = op;
        bus.cmd_use_acc = ua;
    endtask

    logic [3:0] s_a[5], s_b[5], s_r[5];
    logic [2:0] s_op[5];
    logic [3:0] f_a[8], f_b[8], f_r[8];
    logic [2:0] f_op[8];
    int accepted, got, k;

    initial begin
        s_a  = '{4'h2, 4'hC, 4'h1, 4'h6, 4'hF};
        s_b  = '{4'h5, 4'hA, 4'h4, 4'h0, 4'hF};
        s_op = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd7};
        s_r  = '{4'hD, 4'h8, 4'h5, 4'h9, 4'h0};
        f_a  = '{4'h1, 4'h9, 4'h7, 4'h2, 4'h3, 4'hF, 4'h4, 4'h5};
        f_b  = '{4'h1, 4'h3, 4'hC, 4'h8, 4'h0, 4'h2, 4'h4, 4'h1};
        f_op = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd0, 3'd1};
        f_r  = '{4'h2, 4'h6, 4'h4, 4'hA, 4'hC, 4'h1, 4'h8, 4'h4};

        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        bus.rsp_ready = 1'b0;

        // reset state
        #2;
        check("rst_cmd_ready", bus.cmd_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_count", fifo_count, 0);
        #10 rst_n = 1'b1;
        tick();
        check("idle_alu_a", alu_a, 0);
        check("idle_rsp_result", bus.rsp_result, 0);

        // single add, 2-cycle latency
        bus.rsp_ready = 1'b1;
        drive(1'b1, 4'h3, 4'h5, 3'd0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        check("lat_count_e0", fifo_count, 1);
        check("lat_rsp_e0", bus.rsp_valid, 0);
        tick();
        check("lat_alu_a", alu_a, 4'h3);
        check("lat_alu_b", alu_b, 4'h5);
        check("lat_rsp_e1", bus.rsp_valid, 0);
        tick();
        check("lat_rsp_e2", bus.rsp_valid, 1);
        check("lat_result", bus.rsp_result, 4'h8);
        check("lat_opcode", bus.rsp_opcode, 3'd0);
        tick();
        check("lat_rsp_e3", bus.rsp_valid, 0);

        // back-to-back stream, one response per cycle
        for (int i = 0; i < 7; i++) begin
            if (i < 5) drive(1'b1, s_a[i], s_b[i], s_op[i], 1'b0);
            else       drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
            tick();
            if (i >= 2) begin
                check("stream_valid", bus.rsp_valid, 1);
                check("stream_result", bus.rsp_result, s_r[i-2]);
                check("stream_opcode", bus.rsp_opcode, s_op[i-2]);
            end
        end
        tick();
        check("stream_idle", bus.rsp_valid, 0);

        // backpressure: DEPTH+2 accepted, then hold
        bus.rsp_ready = 1'b0;
        accepted = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, f_a[accepted], f_b[accepted], f_op[accepted], 1'b0);
            if (bus.cmd_ready) begin
                exp_q.push_back(f_r[accepted]);
                accepted++;
            end
            tick();
        end
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        check("bp_accepted", accepted, DEPTH + 2);
        check("bp_cmd_ready", bus.cmd_ready, 0);
        check("bp_count", fifo_count, DEPTH);
        for (int c = 0; c < 2; c++) begin
            check("bp_hold_valid", bus.rsp_valid, 1);
            check("bp_hold_result", bus.rsp_result, 4'h2);
            check("bp_hold_opcode", bus.rsp_opcode, 3'd0);
            check("bp_hold_alu_a", alu_a, 4'h9);
            check("bp_hold_alu_op", alu_opcode, 3'd1);
            tick();
        end
        bus.rsp_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
            if (bus.rsp_valid) begin
                check("drain_result", bus.rsp_result, exp_q.pop_front());
                got++;
            end
            tick();
        end
        check("drain_got", got, DEPTH + 2);
        check("drain_left", exp_q.size(), 0);
        check("drain_idle", bus.rsp_valid, 0);
        check("drain_count", fifo_count, 0);
        tick();
        check("drain_no_dup", bus.rsp_valid, 0);

`ifdef ALU_ISSUE_ACC_EN
        // dependent chain through the accumulator
        drive(1'b1, 4'h1, 4'h1, 3'd0, 1'b0);
        tick();
        drive(1'b1, 4'hF, 4'h3, 3'd0, 1'b1);
        tick();
        drive(1'b1, 4'hF, 4'h2, 3'd1, 1'b1);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        check("acc_r0", bus.rsp_result, 4'h2);
        tick();
        check("acc_r1", bus.rsp_result, 4'h5);
        tick();
        check("acc_r2", bus.rsp_result, 4'h3);
        check("acc_valid", bus.rsp_valid, 1);
        tick();
        check("acc_idle", bus.rsp_valid, 0);
`endif

        // asynchronous reset with 3 queued and 1 in flight
        bus.rsp_ready = 1'b0;
        for (k = 0; k < 5; k++) begin
            drive(1'b1, 4'(k + 3), 4'h1, 3'd0, 1'b0);
            tick();
        end
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        check("pre_rst_count", fifo_count, 3);
        check("pre_rst_valid", bus.rsp_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_cmd_ready", bus.cmd_ready, 1);
        check("arst_count", fifo_count, 0);
        check("arst_rsp_valid", bus.rsp_valid, 0);
        check("arst_rsp_result", bus.rsp_result, 0);
        check("arst_rsp_opcode", bus.rsp_opcode, 0);
        check("arst_alu_a", alu_a, 0);
        check("arst_alu_b", alu_b, 0);
        check("arst_alu_op", alu_opcode, 0);
        tick();
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        tick();
        check("post_rst_valid", bus.rsp_valid, 0);
        check("post_rst_count", fifo_count, 0);
        drive(1'b1, 4'h7, 4'h7, 3'd0, 1'b0);
        tick();
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        tick();
        tick();
        check("post_rst_rvalid", bus.rsp_valid, 1);
        check("post_rst_result", bus.rsp_result, 4'hE);
        tick();
        check("post_rst_idle", bus.rsp_valid, 0);

        // clr with a held response and queued commands; concurrent push is refused
        bus.rsp_ready = 1'b0;
        for (k = 0; k < 4; k++) begin
            drive(1'b1, 4'(k + 2), 4'h3, 3'd3, 1'b0);
            tick();
        end
        check("pre_clr_valid", bus.rsp_valid, 1);
        check("pre_clr_count", fifo_count, 2);
        drive(1'b1, 4'h1, 4'h1, 3'd0, 1'b0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        drive(1'b0, 4'h0, 4'h0, 3'd0, 1'b0);
        check("clr_valid", bus.rsp_valid, 0);
        check("clr_count", fifo_count, 0);
        check("clr_cmd_ready", bus.cmd_ready, 1);
        check("clr_alu_op", alu_opcode, 0);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check("clr_no_stale", bus.rsp_valid, 0);
        end
        check("clr_final_count", fifo_count, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
